vga_timing_gen: RTL and testbench

- Pixel-timing generator for the 640x480@60 Hz display path.
- Sits directly upstream of the background/sprite renderers and produces the DrawX, DrawY and blank signals they consume.
- Also produces hs/vs for the VGA connector, per-line and per-frame strobes, and a frame counter for animation.
- Runs entirely in the vga_clk domain (25 MHz nominal).

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-timing generator for the 640x480@60 Hz display path. Produces the
// DrawX/DrawY pixel position consumed by the renderers, the display enable
// (blank), VGA hs/vs, per-line and per-frame strobes and a wrapping frame
// counter. Everything runs on the rising edge of vga_clk.
//
// Ports:
//   vga_clk      in   1   pixel clock
//   reset_n      in   1   synchronous active-low reset
//   hs           out  1   horizontal sync (level SYNC_ACTIVE while asserted)
//   vs           out  1   vertical sync   (level SYNC_ACTIVE while asserted)
//   blank        out  1   1 = visible pixel, 0 = blanking
//   DrawX        out  10  horizontal position
//   DrawY        out  10  vertical position
//   line_start   out  1   high while DrawX == 0
//   frame_start  out  1   high while DrawX == 0 and DrawY == 0
//   frame_count  out  16  frame starts since reset, wrapping
//
// Build option:
//   VGA_TIMING_LOOKAHEAD_EN - when defined, hs/vs/blank/line_start/frame_start
//   get one extra register stage and lag DrawX/DrawY by one vga_clk, for
//   renderers that register colour one cycle after issuing a ROM address.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_nxt, y_nxt;
    logic       hs_nxt, vs_nxt, blank_nxt, line_nxt, frame_nxt;
    logic       hs_r, vs_r, blank_r, line_r, frame_r;

    always_comb begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
    end

    // Decodes look at the next position so the registered strobes line up
    // with the registered DrawX/DrawY.
    always_comb begin
        blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt    = (x_nxt >= HS_BEG && x_nxt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_nxt    = (y_nxt >= VS_BEG && y_nxt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_nxt  = (x_nxt == 10'd0);
        frame_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end

    // Reset parks the position at the last pixel so the first released edge
    // lands on (0,0) and produces a normal frame start.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs_r        <= ~SYNC_ACTIVE;
            vs_r        <= ~SYNC_ACTIVE;
            blank_r     <= 1'b0;
            line_r      <= 1'b0;
            frame_r     <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX   <= x_nxt;
            DrawY   <= y_nxt;
            hs_r    <= hs_nxt;
            vs_r    <= vs_nxt;
            blank_r <= blank_nxt;
            line_r  <= line_nxt;
            frame_r <= frame_nxt;
            if (frame_nxt) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs          <= ~SYNC_ACTIVE;
            vs          <= ~SYNC_ACTIVE;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs          <= hs_r;
            vs          <= vs_r;
            blank       <= blank_r;
            line_start  <= line_r;
            frame_start <= frame_r;
        end
    end
`else
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign blank       = blank_r;
    assign line_start  = line_r;
    assign frame_start = frame_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
    } tp_t;

    typedef struct packed {
        int         t;
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } vec_t;

    localparam tp_t P_DEF = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33};
    localparam tp_t P_SML = '{hv:16, hf:4, hsw:6, hb:6, vv:12, vf:2, vsw:2, vb:3};
    localparam int  S_FRAME = 32 * 19;
    localparam int  HIST = 1701;

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_s_n = 1'b0;

    logic        hs_d, vs_d, blank_d, ls_d, fs_d;
    logic [9:0]  x_d, y_d;
    logic [15:0] fc_d;
    logic        hs_s, vs_s, blank_s, ls_s, fs_s;
    logic [9:0]  x_s, y_s;
    logic [15:0] fc_s;
    obs_t        obs_d, obs_s;

    int n_checks = 0;
    int n_errors = 0;
    int t_d = -1;
    int t_s = -1;
    obs_t hist [HIST];

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset_n(rst_n), .hs(hs_d), .vs(vs_d), .blank(blank_d),
        .DrawX(x_d), .DrawY(y_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(rst_s_n), .hs(hs_s), .vs(vs_s), .blank(blank_s),
        .DrawX(x_s), .DrawY(y_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    assign obs_d = {x_d, y_d, hs_d, vs_d, blank_d, ls_d, fs_d, fc_d};
    assign obs_s = {x_s, y_s, hs_s, vs_s, blank_s, ls_s, fs_s, fc_s};

    // Reference: position is simply elapsed cycles since reset release folded
    // into line/frame lengths; decoded strobes follow the position LAG cycles late.
    function automatic obs_t model(input int t, input tp_t p);
        obs_t o;
        int htot, vtot, td, x, y;
        htot = p.hv + p.hf + p.hsw + p.hb;
        vtot = p.vv + p.vf + p.vsw + p.vb;
        if (t < 0) begin
            o.x  = 10'(htot - 1);
            o.y  = 10'(vtot - 1);
            o.fc = 16'd0;
        end else begin
            o.x  = 10'(t % htot);
            o.y  = 10'((t / htot) % vtot);
            o.fc = 16'((t / (htot * vtot) + 1) % 65536);
        end
        td = t - LAG;
        if (t < 0 || td < 0) begin
            o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
        end else begin
            x = td % htot;
            y = (td / htot) % vtot;
            o.blank = (x < p.hv) && (y < p.vv);
            o.hs    = !(x >= p.hv + p.hf && x < p.hv + p.hf + p.hsw);
            o.vs    = !(y >= p.vv + p.vf && y < p.vv + p.vf + p.vsw);
            o.ls    = (x == 0);
            o.fs    = (x == 0) && (y == 0);
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d actual x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
                     name, t, act.x, act.y, act.hs, act.vs, act.blank, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: advance both elapsed-time trackers according to the reset
    // level present at the edge, then compare both DUTs with the model.
    task automatic tick();
        @(posedge vga_clk);
        #1;
        t_d = rst_n   ? t_d + 1 : -1;
        t_s = rst_s_n ? t_s + 1 : -1;
        check_obs("default_model", t_d, obs_d, model(t_d, P_DEF));
        check_obs("small_model", t_s, obs_s, model(t_s, P_SML));
        if (t_d >= 0 && t_d < HIST) hist[t_d] = obs_d;
    endtask

    vec_t vecs [14];

    initial begin
        int rst_left;
        int fs_first, fs_second, blank_cnt, vs_cnt, budget;
        bit found;

        vecs[0]  = '{t:0,    x:10'd0,   y:10'd0, blank:1, hs:1, vs:1, ls:1, fs:1};
        vecs[1]  = '{t:1,    x:10'd1,   y:10'd0, blank:1, hs:1, vs:1, ls:0, fs:0};
        vecs[2]  = '{t:639,  x:10'd639, y:10'd0, blank:1, hs:1, vs:1, ls:0, fs:0};
        vecs[3]  = '{t:640,  x:10'd640, y:10'd0, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[4]  = '{t:655,  x:10'd655, y:10'd0, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[5]  = '{t:656,  x:10'd656, y:10'd0, blank:0, hs:0, vs:1, ls:0, fs:0};
        vecs[6]  = '{t:751,  x:10'd751, y:10'd0, blank:0, hs:0, vs:1, ls:0, fs:0};
        vecs[7]  = '{t:752,  x:10'd752, y:10'd0, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[8]  = '{t:799,  x:10'd799, y:10'd0, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[9]  = '{t:800,  x:10'd0,   y:10'd1, blank:1, hs:1, vs:1, ls:1, fs:0};
        vecs[10] = '{t:1440, x:10'd640, y:10'd1, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[11] = '{t:1456, x:10'd656, y:10'd1, blank:0, hs:0, vs:1, ls:0, fs:0};
        vecs[12] = '{t:1599, x:10'd799, y:10'd1, blank:0, hs:1, vs:1, ls:0, fs:0};
        vecs[13] = '{t:1600, x:10'd0,   y:10'd2, blank:1, hs:1, vs:1, ls:1, fs:0};

        // Reset held for three edges.
        rst_n = 1'b0; rst_s_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_int("reset_drawx", int'(x_d), 799);
        check_int("reset_drawy", int'(y_d), 524);
        check_int("reset_hs_vs", int'({hs_d, vs_d}), 3);
        check_int("reset_blank", int'(blank_d), 0);
        check_int("reset_frame_count", int'(fc_d), 0);

        rst_n = 1'b1; rst_s_n = 1'b1;
        tick();
        check_int("first_drawxy", int'({x_d, y_d}), 0);
        check_int("first_frame_start", int'(fs_d), LAG == 0 ? 1 : 0);
        check_int("first_frame_count", int'(fc_d), 1);
        for (int i = 1; i < HIST; i++) tick();

        // Table of hand-derived positions on the default-size instance.
        for (int i = 0; i < 14; i++) begin
            obs_t a, b;
            a = hist[vecs[i].t];
            b = hist[vecs[i].t + LAG];
            n_checks++;
            if ({a.x, a.y, b.blank, b.hs, b.vs, b.ls, b.fs, a.fc} !==
                {vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs, 16'd1}) begin
                n_errors++;
                $display("FAIL vec%0d t=%0d actual x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=1",
                         i, vecs[i].t, a.x, a.y, b.blank, b.hs, b.vs, b.ls, b.fs, a.fc,
                         vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs);
            end
        end

        // Random reset pulses on the small instance across many frames.
        rst_left = 0;
        for (int i = 0; i < 6000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 999) == 0) rst_left = $urandom_range(1, 3);
            rst_s_n = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            tick();
        end
        rst_s_n = 1'b1;
        tick();

        // One-edge reset while inside vertical sync with hs asserted.
        found = 0;
        budget = 3 * S_FRAME;
        while (!found && budget > 0) begin
            if (y_s == 10'd15 && hs_s == 1'b0) found = 1;
            else begin tick(); budget--; end
        end
        check_int("vsync_hs_reached", int'(found), 1);
        rst_s_n = 1'b0;
        tick();
        check_int("midsync_drawx", int'(x_s), 31);
        check_int("midsync_drawy", int'(y_s), 18);
        check_int("midsync_hs_vs", int'({hs_s, vs_s}), 3);
        check_int("midsync_frame_count", int'(fc_s), 0);
        rst_s_n = 1'b1;

        // Two frames after release: period, visible and vsync cycle counts.
        fs_first = -1; fs_second = -1; blank_cnt = 0; vs_cnt = 0;
        for (int k = 0; k < 2 * S_FRAME + 2; k++) begin
            tick();
            if (k < S_FRAME) begin
                if (blank_s) blank_cnt++;
                if (!vs_s) vs_cnt++;
            end
            if (fs_s) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
        end
        check_int("small_first_fs", fs_first, LAG);
        check_int("small_fs_period", fs_second - fs_first, S_FRAME);
        check_int("small_blank_cycles", blank_cnt, 16 * 12);
        check_int("small_vs_cycles", vs_cnt, 2 * 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
